// File: rtl/bit_adder_pkg.sv
// Shared constants and width helpers for the pipelined bit adder.
// Optional feature macro: BIT_ADDER_ACC_EN (accumulation over ACC_LEN beats).
package bit_adder_pkg;

  localparam int DEF_M       = 16;
  localparam int DEF_PA      = 8;
  localparam int DEF_PW      = 4;
  localparam int DEF_ACC_LEN = 4;

`ifdef BIT_ADDER_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  // Width of one input lane.
  function automatic int lane_width(input int pa, input int pw);
    return pa + pw;
  endfunction

  // Width of each sum produced by tree level k (level 0 adds raw lanes).
  function automatic int level_width(input int w, input int k);
    return w + k + 1;
  endfunction

  // Beat counter width; a one-beat group still needs a one-bit register.
  function automatic int cnt_width(input int acc_len);
    return (acc_len > 1) ? $clog2(acc_len) : 1;
  endfunction

  // Width of out_ba: tree growth plus accumulation growth when enabled.
  function automatic int out_width(input int w, input int m, input int acc_len);
    return w + $clog2(m) + (ACC_EN ? $clog2(acc_len) : 0);
  endfunction

endpackage

// File: rtl/pipelined_bit_adder_tree_level.sv
// One registered pairwise level of the adder tree: N operands in, N/2 sums out.
// Sums capture only on an enabled, valid beat; clr drops the valid bit regardless of enable.
module adder_tree_level #(
  parameter int N  = 2,
  parameter int IW = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [N-1:0][IW-1:0]      in_data,
  input  logic                      in_valid,
  output logic [N/2-1:0][IW:0]      out_data,
  output logic                      out_valid
);

  logic [N/2-1:0][IW:0] sum_s;

  // Pairwise sums, each one bit wider than its operands so nothing overflows.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < N/2; i++) begin
      sum_s[i] = {1'b0, in_data[2*i]} + {1'b0, in_data[2*i+1]};
    end
  end

  // Level register: valid follows the advance enable, data only moves on real beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clr) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= in_valid;
      end else begin
        out_valid <= out_valid;
      end
      if (en && in_valid && !clr) begin
        out_data <= sum_s;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: rtl/pipelined_bit_adder.sv
// Pipelined unsigned sum of M lanes through a registered binary adder tree.
// Macro BIT_ADDER_ACC_EN adds an accumulator that emits one sum per ACC_LEN beats.
// A single advance enable (output empty or being taken) moves every register.
module pipelined_bit_adder
  import bit_adder_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int Pa      = DEF_PA,
  parameter int Pw      = DEF_PW,
  parameter int ACC_LEN = DEF_ACC_LEN
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [M-1:0][lane_width(Pa, Pw)-1:0]                in_ba,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  output logic [out_width(lane_width(Pa, Pw), M, ACC_LEN)-1:0] out_ba,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  input  logic                                                acc_clr
);

  localparam int W   = lane_width(Pa, Pw);
  localparam int LVL = $clog2(M);
  localparam int TW  = level_width(W, LVL - 1);
  localparam int OW  = out_width(W, M, ACC_LEN);

  logic          adv_s;
  logic          clr_s;
  logic [TW-1:0] tree_data_s;
  logic          tree_valid_s;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

`ifdef BIT_ADDER_ACC_EN
  assign clr_s = acc_clr;
`else
  logic unused_acc_clr_s;
  assign unused_acc_clr_s = acc_clr;
  assign clr_s            = 1'b0;
`endif

  genvar k;
  for (k = 0; k < LVL; k++) begin : g_lvl
    localparam int N  = M >> k;
    localparam int IW = W + k;
    logic [N/2-1:0][IW:0] data_s;
    logic                 valid_s;
    if (k == 0) begin : g_first
      adder_tree_level #(.N(N), .IW(IW)) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv_s),
        .clr       (clr_s),
        .in_data   (in_ba),
        .in_valid  (in_valid),
        .out_data  (data_s),
        .out_valid (valid_s)
      );
    end else begin : g_next
      adder_tree_level #(.N(N), .IW(IW)) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv_s),
        .clr       (clr_s),
        .in_data   (g_lvl[k-1].data_s),
        .in_valid  (g_lvl[k-1].valid_s),
        .out_data  (data_s),
        .out_valid (valid_s)
      );
    end
  end

  assign tree_data_s  = g_lvl[LVL-1].data_s[0];
  assign tree_valid_s = g_lvl[LVL-1].valid_s;

`ifdef BIT_ADDER_ACC_EN
  localparam int            CW       = cnt_width(ACC_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);

  logic [OW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic [OW-1:0] acc_sum_s;

  assign acc_sum_s = acc_r + OW'(tree_data_s);

  // Accumulate tree beats; the last beat of a group emits and restarts the group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      out_ba    <= '0;
      out_valid <= 1'b0;
    end else if (clr_s) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      out_ba    <= out_ba;
      out_valid <= adv_s ? 1'b0 : out_valid;
    end else if (adv_s) begin
      if (tree_valid_s && (cnt_r == CNT_LAST)) begin
        acc_r     <= '0;
        cnt_r     <= '0;
        out_ba    <= acc_sum_s;
        out_valid <= 1'b1;
      end else if (tree_valid_s) begin
        acc_r     <= acc_sum_s;
        cnt_r     <= cnt_r + 1'b1;
        out_ba    <= out_ba;
        out_valid <= 1'b0;
      end else begin
        acc_r     <= acc_r;
        cnt_r     <= cnt_r;
        out_ba    <= out_ba;
        out_valid <= 1'b0;
      end
    end else begin
      acc_r     <= acc_r;
      cnt_r     <= cnt_r;
      out_ba    <= out_ba;
      out_valid <= out_valid;
    end
  end
`else
  // The final tree level register is the output register.
  assign out_ba    = OW'(tree_data_s);
  assign out_valid = tree_valid_s;
`endif

endmodule

// File: tb/tb_pipelined_bit_adder.sv
// Scoreboard bench for pipelined_bit_adder (M=16, Pa=8, Pw=4, ACC_LEN=4).
// Follows BIT_ADDER_ACC_EN to pick the expected responses.
module tb_pipelined_bit_adder;
  import bit_adder_pkg::*;

  localparam int M       = 16;
  localparam int PA      = 8;
  localparam int PW      = 4;
  localparam int ACC_LEN = 4;
  localparam int W       = lane_width(PA, PW);
  localparam int OW      = out_width(W, M, ACC_LEN);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [M-1:0][W-1:0] in_ba;
  logic                in_valid;
  logic                in_ready;
  logic [OW-1:0]       out_ba;
  logic                out_valid;
  logic                out_ready;
  logic                acc_clr;

  int            cyc = 0;
  int            n_vec = 0;
  int            n_mis = 0;
  logic [63:0]   exp_q[$];
  int            pop_cyc_q[$];

  pipelined_bit_adder #(.M(M), .Pa(PA), .Pw(PW), .ACC_LEN(ACC_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ba     (in_ba),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ba    (out_ba),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_clr   (acc_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_output: got %0d, expected none", out_ba);
      end else begin
        check("out_ba", 64'(out_ba), exp_q.pop_front());
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  task automatic set_uniform(input int v);
    for (int i = 0; i < M; i++) in_ba[i] = W'(v);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < M; i++) in_ba[i] = W'(i);
  endtask

  task automatic push_n(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Present the current in_ba until accepted; acc_cyc is the acceptance cycle.
  task automatic send_beat(output int acc_cyc);
    acc_cyc  = -1;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec++;
    n_mis++;
    $display("FAIL accept_timeout: got no in_ready, expected acceptance");
  endtask

  task automatic send_n(input int n);
    int c;
    for (int i = 0; i < n; i++) send_beat(c);
  endtask

  // Cycles from acceptance until out_valid first seen (-1 if it never shows).
  task automatic measure_latency(input int acc_cyc, output int lat);
    lat = -1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int lat;
    logic [63:0] stall_val;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_clr   = 1'b0;
    in_ba     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_ba", 64'(out_ba), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All lanes at maximum.
    set_uniform(12'hFFF);
`ifdef BIT_ADDER_ACC_EN
    push_n(64'd262080, 1);
    send_n(3);
    send_beat(a);
    measure_latency(a, lat);
    check("acc_latency", 64'(lat), 64'd5);
    set_uniform(2);
    push_n(64'd128, 1);
    send_n(4);
`else
    push_n(64'd65520, 1);
    send_beat(a);
    measure_latency(a, lat);
    check("tree_latency", 64'(lat), 64'd4);
`endif
    wait_drain("drain_max");

    // Lane i = i, eight beats back to back.
    set_ramp();
    pop_cyc_q.delete();
`ifdef BIT_ADDER_ACC_EN
    push_n(64'd480, 2);
    send_n(8);
    wait_drain("drain_ramp");
    check("ramp_count", 64'(pop_cyc_q.size()), 64'd2);
    check("ramp_span", 64'(pop_cyc_q[1] - pop_cyc_q[0]), 64'd4);
`else
    push_n(64'd120, 8);
    send_n(8);
    wait_drain("drain_ramp");
    check("ramp_count", 64'(pop_cyc_q.size()), 64'd8);
    check("ramp_span", 64'(pop_cyc_q[7] - pop_cyc_q[0]), 64'd7);
`endif

    // Output stall for six cycles.
    out_ready = 1'b0;
`ifdef BIT_ADDER_ACC_EN
    push_n(64'd144, 1);
    stall_val = 64'd144;
`else
    push_n(64'd16, 1);
    push_n(64'd48, 1);
    push_n(64'd64, 1);
    push_n(64'd16, 1);
    stall_val = 64'd16;
`endif
    set_uniform(1);
    send_beat(a);
    set_uniform(3);
    send_beat(a);
    set_uniform(4);
    send_beat(a);
    set_uniform(1);
    send_beat(a);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_ba", 64'(out_ba), stall_val);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_stall");

    // Partial group discarded by acc_clr.
    set_uniform(1);
`ifdef BIT_ADDER_ACC_EN
    push_n(64'd64, 1);
`else
    push_n(64'd16, 6);
`endif
    send_n(2);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    send_n(4);
    wait_drain("drain_clr");

    // Reset in the middle of a group.
    set_uniform(1);
    send_n(3);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_ba", 64'(out_ba), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_uniform(2);
`ifdef BIT_ADDER_ACC_EN
    push_n(64'd128, 1);
`else
    push_n(64'd32, 4);
`endif
    send_n(4);
    wait_drain("drain_reset");

    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
